// File: rtl/sci_pkg.sv
// Shared SCI arbitration definitions: FSM encoding and packed-vector helpers.
package sci_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Low bit of requester idx's field inside a packed per-requester vector.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request after the last winner, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic [NUM_REQ-1:0] req,
  input  logic               take,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [IW-1:0]      grant_idx,
  output logic               any_req
);

  logic [IW-1:0] ptr;
  logic          found;

  function automatic logic [IW-1:0] wrap(input logic [IW-1:0] p, input int k);
    int s;
    s = (int'(p) + k) % NUM_REQ;
    return IW'(s);
  endfunction

  // Search from ptr+1 so the previous winner is checked last.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req[wrap(ptr, k)]) begin
        found     = 1'b1;
        grant_idx = wrap(ptr, k);
      end
    end
    if (found) grant_oh[grant_idx] = 1'b1;
    any_req = |req;
  end

  // Pointer parks on the last winner; reset value makes requester 0 first.
  always_ff @(posedge CLK) begin
    if (!RSTN)     ptr <= IW'(NUM_REQ - 1);
    else if (take) ptr <= grant_idx;
  end

endmodule

// File: rtl/sci_master_arbiter.sv
// Shares one SCI_MASTER request port among NUM_REQ requesters with
// round-robin grant, REQ-low gap between transfers and hung-transfer timeout.
module sci_master_arbiter
  import sci_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int ADDR_WIDTH      = 4,
  parameter int DATA_WIDTH      = 8,
  parameter int NUM_PERIPHERALS = 2,
  parameter int GAP_CYCLES      = 2,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic                               CLK,
  input  logic                               RSTN,
  input  logic [NUM_REQ-1:0]                 REQ_VALID,
  input  logic [NUM_REQ-1:0]                 REQ_WNR,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]      REQ_ADDR,
  input  logic [NUM_REQ*NUM_PERIPHERALS-1:0] REQ_CSN,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      REQ_WDATA,
  output logic [NUM_REQ-1:0]                 REQ_ACK,
  output logic                               REQ_ERR,
  output logic [DATA_WIDTH-1:0]              REQ_RDATA,
  output logic                               BUSY,
  output logic                               M_RSTN,
  output logic                               M_REQ,
  output logic                               M_WNR,
  output logic [ADDR_WIDTH-1:0]              M_ADDR,
  output logic [NUM_PERIPHERALS-1:0]         M_CSN,
  output logic [DATA_WIDTH-1:0]              M_WDATA,
  input  logic                               M_ACK,
  input  logic [DATA_WIDTH-1:0]              M_RDATA
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + GAP_CYCLES) + 1;
  localparam logic [NUM_PERIPHERALS-1:0] CSN_NONE = '1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  // The IDLE arbitration cycle also keeps M_REQ low, so GAP covers the
  // remaining GAP_CYCLES-1 cycles (skipped entirely when GAP_CYCLES is 1).
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);
  localparam state_t        GAP_ENTRY = (GAP_CYCLES > 1) ? ST_GAP : ST_IDLE;

  typedef struct packed {
    logic                       wnr;
    logic [ADDR_WIDTH-1:0]      addr;
    logic [NUM_PERIPHERALS-1:0] csn;
    logic [DATA_WIDTH-1:0]      wdata;
  } sci_req_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [NUM_REQ-1:0] gnt_oh, cur_oh;
  logic [IW-1:0]      gnt_idx;
  logic               any_req, take, fin_ok, fin_err, tmo;
  sci_req_t           gnt_req;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .req      (REQ_VALID),
    .take     (take),
    .grant_oh (gnt_oh),
    .grant_idx(gnt_idx),
    .any_req  (any_req)
  );

  // Mux the granted requester's payload out of the packed request buses.
  always_comb begin
    gnt_req.wnr   = REQ_WNR[gnt_idx];
    gnt_req.addr  = REQ_ADDR[slice_lo(int'(gnt_idx), ADDR_WIDTH) +: ADDR_WIDTH];
    gnt_req.csn   = REQ_CSN[slice_lo(int'(gnt_idx), NUM_PERIPHERALS) +: NUM_PERIPHERALS];
    gnt_req.wdata = REQ_WDATA[slice_lo(int'(gnt_idx), DATA_WIDTH) +: DATA_WIDTH];
  end

  // Next-state logic; one counter serves both the BUSY timeout and the GAP.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    take      = 1'b0;
    fin_ok    = 1'b0;
    fin_err   = 1'b0;
    tmo       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          take    = 1'b1;
          cnt_nxt = '0;
          if (gnt_req.csn == CSN_NONE) begin
            fin_err   = 1'b1;
            state_nxt = GAP_ENTRY;
          end else begin
            state_nxt = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (M_ACK) begin
          fin_ok    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = GAP_ENTRY;
        end else if (cnt == TMO_LAST) begin
          fin_err   = 1'b1;
          tmo       = 1'b1;
          cnt_nxt   = '0;
          state_nxt = GAP_ENTRY;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Registered outputs: master request side, completion pulse, master reset.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      REQ_ACK   <= '0;
      REQ_ERR   <= 1'b0;
      REQ_RDATA <= '0;
      BUSY      <= 1'b0;
      M_RSTN    <= 1'b0;
      M_REQ     <= 1'b0;
      M_WNR     <= 1'b0;
      M_ADDR    <= '0;
      M_CSN     <= CSN_NONE;
      M_WDATA   <= '0;
      cur_oh    <= '0;
    end else begin
      REQ_ACK <= '0;
      REQ_ERR <= 1'b0;
      M_RSTN  <= ~tmo;
      BUSY    <= (state_nxt != ST_IDLE);
      if (take) begin
        cur_oh  <= gnt_oh;
        M_WNR   <= gnt_req.wnr;
        M_ADDR  <= gnt_req.addr;
        M_CSN   <= gnt_req.csn;
        M_WDATA <= gnt_req.wdata;
        M_REQ   <= (gnt_req.csn != CSN_NONE);
      end
      if (fin_ok || fin_err) begin
        REQ_ACK   <= take ? gnt_oh : cur_oh;
        REQ_ERR   <= fin_err;
        REQ_RDATA <= (fin_ok && !M_WNR) ? M_RDATA : '0;
        M_REQ     <= 1'b0;
        M_CSN     <= CSN_NONE;
      end
    end
  end

endmodule

// File: tb/tb_sci_master_arbiter.sv
// Directed bench for sci_master_arbiter with a small SCI_MASTER model and an
// ACK scoreboard (expected completions queued when requests are raised).
module tb_sci_master_arbiter;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic [3:0]  REQ_VALID, REQ_WNR, REQ_ACK;
  logic [15:0] REQ_ADDR;
  logic [7:0]  REQ_CSN;
  logic [31:0] REQ_WDATA;
  logic        REQ_ERR, BUSY, M_RSTN, M_REQ, M_WNR, M_ACK;
  logic [7:0]  REQ_RDATA, M_WDATA, M_RDATA;
  logic [3:0]  M_ADDR;
  logic [1:0]  M_CSN;

  sci_master_arbiter dut (
    .CLK(CLK), .RSTN(RSTN), .REQ_VALID(REQ_VALID), .REQ_WNR(REQ_WNR),
    .REQ_ADDR(REQ_ADDR), .REQ_CSN(REQ_CSN), .REQ_WDATA(REQ_WDATA),
    .REQ_ACK(REQ_ACK), .REQ_ERR(REQ_ERR), .REQ_RDATA(REQ_RDATA), .BUSY(BUSY),
    .M_RSTN(M_RSTN), .M_REQ(M_REQ), .M_WNR(M_WNR), .M_ADDR(M_ADDR),
    .M_CSN(M_CSN), .M_WDATA(M_WDATA), .M_ACK(M_ACK), .M_RDATA(M_RDATA)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] oh;
    logic       err;
    logic [7:0] rdata;
  } exp_t;

  exp_t sb[$];
  int vectors = 0, miscompares = 0;
  int busy_cnt = 0, hold_acks = 0, acks_seen = 0;
  int low_run = 0, hi_run = 0, last_hi_run = 0;
  bit ack_en = 1, ack_done = 0, gap_chk = 0, seen_fall = 0, prev_mreq = 0;
  localparam int LAT = 3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] oh, input logic err, input logic [7:0] rd);
    exp_t e;
    e.oh = oh; e.err = err; e.rdata = rd;
    sb.push_back(e);
  endtask

  task automatic set_req(input int i, input logic wnr, input logic [3:0] a,
                         input logic [1:0] csn, input logic [7:0] wd);
    REQ_WNR[i]        = wnr;
    REQ_ADDR[i*4 +: 4] = a;
    REQ_CSN[i*2 +: 2]  = csn;
    REQ_WDATA[i*8 +: 8] = wd;
    REQ_VALID[i]      = 1'b1;
  endtask

  // One clock: sample after the edge, run the master model, track M_REQ
  // runs, and score any completion pulse.
  task automatic cyc();
    exp_t e;
    @(posedge CLK); #1;
    M_ACK = 1'b0;
    if (M_REQ) begin
      if (ack_en && !ack_done) begin
        busy_cnt++;
        if (busy_cnt == LAT) begin M_ACK = 1'b1; ack_done = 1; end
      end
      hi_run++;
    end else begin
      busy_cnt = 0; ack_done = 0;
      if (prev_mreq) begin seen_fall = 1; low_run = 0; last_hi_run = hi_run; end
      hi_run = 0;
      low_run++;
    end
    if (M_REQ && !prev_mreq && gap_chk && seen_fall) chk("gap_len", low_run, 2);
    prev_mreq = M_REQ;
    if (REQ_ACK != 4'b0) begin
      acks_seen++;
      if (sb.size() == 0) chk("unexpected_ack", {28'b0, REQ_ACK}, 0);
      else begin
        e = sb.pop_front();
        chk("ack_onehot", {28'b0, REQ_ACK}, {28'b0, e.oh});
        chk("ack_err", {31'b0, REQ_ERR}, {31'b0, e.err});
        chk("ack_rdata", {24'b0, REQ_RDATA}, {24'b0, e.rdata});
      end
      if (hold_acks > 1) hold_acks--;
      else if (hold_acks == 1) begin hold_acks = 0; REQ_VALID = '0; end
      else REQ_VALID = REQ_VALID & ~REQ_ACK;
    end
  endtask

  task automatic drain(input string tag, input int maxc);
    int n = 0;
    while (sb.size() != 0 && n < maxc) begin cyc(); n++; end
    chk({"drain_", tag}, sb.size(), 0);
  endtask

  initial begin
    int n;
    int a0;
    RSTN = 1'b0; REQ_VALID = '0; REQ_WNR = '0; REQ_ADDR = '0; REQ_CSN = '1;
    REQ_WDATA = '0; M_ACK = 1'b0; M_RDATA = 8'h00;
    repeat (3) cyc();
    chk("rst_ack", {28'b0, REQ_ACK}, 0);
    chk("rst_err", {31'b0, REQ_ERR}, 0);
    chk("rst_rdata", {24'b0, REQ_RDATA}, 0);
    chk("rst_busy", {31'b0, BUSY}, 0);
    chk("rst_mreq", {31'b0, M_REQ}, 0);
    chk("rst_mcsn", {30'b0, M_CSN}, 3);
    chk("rst_mrstn", {31'b0, M_RSTN}, 0);
    RSTN = 1'b1;
    cyc();
    chk("mrstn_release", {31'b0, M_RSTN}, 1);

    // Fairness: all four continuously valid, grants 0,1,2,3,0.
    M_RDATA = 8'h11;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 4'(i + 1), (i % 2 == 0) ? 2'b10 : 2'b01, 8'(8'h20 + i));
    push(4'b0001, 0, 0); push(4'b0010, 0, 0); push(4'b0100, 0, 0);
    push(4'b1000, 0, 0); push(4'b0001, 0, 0);
    hold_acks = 5; gap_chk = 1; seen_fall = 0;
    drain("fair", 200);
    gap_chk = 0;
    repeat (4) cyc();

    // Req0 write: M_REQ the cycle after REQ_VALID, payload held, write RDATA=0.
    M_RDATA = 8'hFF;
    push(4'b0001, 0, 8'h00);
    set_req(0, 1'b1, 4'hA, 2'b10, 8'h5C);
    cyc();
    chk("wr_mreq", {31'b0, M_REQ}, 1);
    chk("wr_mwnr", {31'b0, M_WNR}, 1);
    chk("wr_maddr", {28'b0, M_ADDR}, 32'hA);
    chk("wr_mcsn", {30'b0, M_CSN}, 2);
    chk("wr_mwdata", {24'b0, M_WDATA}, 32'h5C);
    chk("wr_busy", {31'b0, BUSY}, 1);
    cyc();
    chk("wr_mwdata_held", {24'b0, M_WDATA}, 32'h5C);
    drain("write", 50);
    repeat (3) cyc();

    // Req2 read: master data returned with the ACK.
    M_RDATA = 8'hA7;
    push(4'b0100, 0, 8'hA7);
    set_req(2, 1'b0, 4'h3, 2'b01, 8'h00);
    cyc();
    chk("rd_maddr", {28'b0, M_ADDR}, 3);
    drain("read", 50);
    repeat (3) cyc();

    // Req1 with no chip select: error ACK, master never requested.
    push(4'b0010, 1, 8'h00);
    set_req(1, 1'b1, 4'h5, 2'b11, 8'h33);
    cyc();
    chk("csn_ack_latency", sb.size(), 0);
    chk("csn_no_mreq", {31'b0, M_REQ}, 0);
    repeat (2) cyc();
    chk("csn_no_mreq_later", {31'b0, M_REQ}, 0);
    repeat (3) cyc();

    // Timeout on req3 read, then req0 served once the master answers again.
    ack_en = 0; M_RDATA = 8'h5A;
    push(4'b1000, 1, 8'h00); push(4'b0001, 0, 8'h00);
    set_req(3, 1'b0, 4'h7, 2'b01, 8'h00);
    set_req(0, 1'b1, 4'h2, 2'b10, 8'h66);
    a0 = acks_seen; n = 0;
    while (acks_seen == a0 && n < 400) begin cyc(); n++; end
    chk("tmo_seen", {31'b0, acks_seen != a0}, 1);
    chk("tmo_busy_cycles", last_hi_run, 256);
    chk("tmo_mrstn_low", {31'b0, M_RSTN}, 0);
    ack_en = 1;
    cyc();
    chk("tmo_mrstn_back", {31'b0, M_RSTN}, 1);
    drain("after_tmo", 50);
    repeat (3) cyc();

    // Reset mid-BUSY: everything back to reset values, req0 wins afterwards.
    ack_en = 0;
    set_req(1, 1'b1, 4'h9, 2'b01, 8'h77);
    repeat (4) cyc();
    chk("mid_busy", {31'b0, BUSY}, 1);
    RSTN = 1'b0;
    cyc();
    chk("rst2_mreq", {31'b0, M_REQ}, 0);
    chk("rst2_mcsn", {30'b0, M_CSN}, 3);
    chk("rst2_mrstn", {31'b0, M_RSTN}, 0);
    chk("rst2_ack", {28'b0, REQ_ACK}, 0);
    chk("rst2_busy", {31'b0, BUSY}, 0);
    sb.delete();
    set_req(0, 1'b1, 4'h4, 2'b10, 8'h99);
    push(4'b0001, 0, 8'h00); push(4'b0010, 0, 8'h00);
    ack_en = 1; RSTN = 1'b1;
    cyc();
    chk("rst2_first_mreq", {31'b0, M_REQ}, 1);
    chk("rst2_first_addr", {28'b0, M_ADDR}, 4);
    drain("after_rst", 100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
